// File: rtl/noc_types.sv
// +----------------------------------------------------------------------------+
// | noc_types : shared NoC flit type, requester defaults and FSM encoding      |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package noc_types;

  localparam int FLIT_W = 32;

  typedef logic [FLIT_W-1:0] flit_t;

  localparam int ACK_TIMEOUT_DEF    = 64;
  localparam int BACKOFF_CYCLES_DEF = 8;
  localparam int MAX_RETRIES_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DROP    = 3'd4
  } req_state_t;

endpackage

`default_nettype wire

// File: rtl/node_port.sv
// +----------------------------------------------------------------------------+
// | node_port : point-to-point link; upstream drives flit/enable, gets ack/rej |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface node_port;
  noc_types::flit_t flit;
  logic             enable;
  logic             ack;
  logic             rej;

  modport up   (output flit, output enable, input  ack, input  rej);
  modport down (input  flit, input  enable, output ack, output rej);
endinterface

`default_nettype wire

// File: rtl/path_requester.sv
// +----------------------------------------------------------------------------+
// | path_requester : requests a downstream path with the packet header, retries|
// |                  with backoff on rejection, then streams the payload        |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module path_requester
  import noc_types::*;
#(
  parameter int ACK_TIMEOUT    = ACK_TIMEOUT_DEF,
  parameter int BACKOFF_CYCLES = BACKOFF_CYCLES_DEF,
  parameter int MAX_RETRIES    = MAX_RETRIES_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  flit_t  src_flit,
  input  logic   src_valid,
  input  logic   src_last,
  output logic   src_ready,
  node_port.up   up,
  output logic   busy,
  output logic   err
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ACK_TIMEOUT);
  localparam logic [BO_W-1:0]  BO_LAST  = BO_W'(BACKOFF_CYCLES - 1);
  localparam logic [BO_W-1:0]  BO_MAX   = BO_W'(BACKOFF_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  req_state_t       state_q, state_d;
  flit_t            hdr_q, hdr_d;
  logic             hdr_last_q, hdr_last_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [BO_W-1:0]  bo_q, bo_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             err_q, err_d;
  // Held low through reset so src_ready only rises on the first clock edge.
  logic             rdy_en_q;

  logic             ready_w;
  logic             enable_w;
  flit_t            flit_w;

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    hdr_last_d = hdr_last_q;
    tmo_d      = tmo_q;
    bo_d       = bo_q;
    retry_d    = retry_q;
    err_d      = 1'b0;
    ready_w    = 1'b0;
    enable_w   = 1'b0;
    flit_w     = '0;

    case (state_q)
      ST_IDLE: begin
        ready_w = rdy_en_q;
        if (src_valid && rdy_en_q) begin
          hdr_d      = src_flit;
          hdr_last_d = src_last;
          retry_d    = '0;
          tmo_d      = '0;
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        enable_w = 1'b1;
        flit_w   = hdr_q;
        if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (up.ack && !up.rej) begin
          if (hdr_last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STREAM;
          end
        end else if (up.rej || (tmo_q == TMO_LAST)) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            bo_d    = '0;
            state_d = ST_BACKOFF;
          end else begin
            err_d = 1'b1;
            if (hdr_last_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
      end

      ST_BACKOFF: begin
        if (bo_q != BO_MAX) begin
          bo_d = bo_q + BO_W'(1);
        end
        if (bo_q == BO_LAST) begin
          tmo_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_STREAM: begin
        flit_w = src_flit;
        // A mid-stream reject tears the path down before this cycle's flit.
        if (up.rej) begin
          err_d   = 1'b1;
          state_d = ST_DROP;
        end else begin
          ready_w  = 1'b1;
          enable_w = src_valid;
          if (src_valid && src_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        ready_w = 1'b1;
        if (src_valid && src_last) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      hdr_last_q <= 1'b0;
      tmo_q      <= '0;
      bo_q       <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      hdr_last_q <= hdr_last_d;
      tmo_q      <= tmo_d;
      bo_q       <= bo_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign src_ready = ready_w;
  assign up.enable = enable_w;
  assign up.flit   = flit_w;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_path_requester.sv
// +----------------------------------------------------------------------------+
// | tb_path_requester : packet-level reference timeline vs. path_requester     |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_path_requester;
  import noc_types::*;

  localparam int AT = ACK_TIMEOUT_DEF;
  localparam int BO = BACKOFF_CYCLES_DEF;
  localparam int MR = MAX_RETRIES_DEF;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  flit_t src_flit;
  logic  src_valid, src_last, src_ready, busy, err;

  node_port link ();

  path_requester #(
    .ACK_TIMEOUT   (AT),
    .BACKOFF_CYCLES(BO),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_flit (src_flit),
    .src_valid(src_valid),
    .src_last (src_last),
    .src_ready(src_ready),
    .up       (link),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // One cycle of source/link stimulus plus the outputs the rules predict.
  typedef struct {
    logic  v; flit_t f; logic l; logic ack; logic rej;
    logic  rdy; logic en; flit_t ef; logic bsy; logic er;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic pend_err = 1'b0;
  logic gaps_on = 1'b1;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic v, input flit_t f, input logic l, input logic ack,
                     input logic rej, input logic rdy, input logic en, input flit_t ef,
                     input logic bsy);
    cyc_t c;
    c.v = v; c.f = f; c.l = l; c.ack = ack; c.rej = rej;
    c.rdy = rdy; c.en = en; c.ef = ef; c.bsy = bsy; c.er = pend_err;
    pend_err = 1'b0;
    q.push_back(c);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Packet: len flits, first nrej attempts rejected (first one by timeout if
  // tmo_first), optional reject while streaming payload index srej.
  task automatic gen_pkt(input int len, input int nrej, input logic tmo_first,
                         input int srej, input int wfix);
    flit_t hdr;
    flit_t pl[$];
    flit_t hold_f;
    logic  hold_l;
    int    retries;
    logic  dropped;
    int    start;
    int    w;
    hdr = $urandom;
    for (int i = 0; i < len - 1; i++) pl.push_back($urandom);
    hold_f = (len > 1) ? pl[0] : '0;
    hold_l = (len == 2);
    if (gaps_on) repeat ($urandom_range(0, 2))
      add(1'b0, $urandom, rb(), rb(), rb(), 1'b1, 1'b0, '0, 1'b0);
    add(1'b1, hdr, len == 1, rb(), rb(), 1'b1, 1'b0, '0, 1'b0);
    retries = 0;
    dropped = 1'b0;
    for (int a = 0; a <= MR; a++) begin
      if (a == 0 && tmo_first && nrej > 0) begin
        repeat (AT) add((len > 1) && rb(), hold_f, hold_l, 1'b0, 1'b0, 1'b0, 1'b1, hdr, 1'b1);
      end else begin
        w = (wfix >= 0) ? wfix : $urandom_range(0, 3);
        repeat (w) add((len > 1) && rb(), hold_f, hold_l, 1'b0, 1'b0, 1'b0, 1'b1, hdr, 1'b1);
        if (a < nrej) begin
          add((len > 1) && rb(), hold_f, hold_l, rb(), 1'b1, 1'b0, 1'b1, hdr, 1'b1);
        end else begin
          add((len > 1) && rb(), hold_f, hold_l, 1'b1, 1'b0, 1'b0, 1'b1, hdr, 1'b1);
          break;
        end
      end
      if (retries == MR) begin
        pend_err = 1'b1;
        dropped  = 1'b1;
        break;
      end
      retries++;
      repeat (BO) add((len > 1) && rb(), hold_f, hold_l, rb(), rb(), 1'b0, 1'b0, '0, 1'b1);
    end
    start = 0;
    if (!dropped) begin
      for (int i = 0; i < len - 1; i++) begin
        if (gaps_on && $urandom_range(0, 3) == 0)
          add(1'b0, $urandom, rb(), rb(), 1'b0, 1'b1, 1'b0, '0, 1'b1);
        if (i == srej) begin
          add(1'b1, pl[i], i == len - 2, rb(), 1'b1, 1'b0, 1'b0, '0, 1'b1);
          pend_err = 1'b1;
          dropped  = 1'b1;
          start    = i;
          break;
        end
        add(1'b1, pl[i], i == len - 2, rb(), 1'b0, 1'b1, 1'b1, pl[i], 1'b1);
      end
    end
    if (dropped) begin
      for (int i = start; i < len - 1; i++) begin
        if (gaps_on && $urandom_range(0, 3) == 0)
          add(1'b0, $urandom, rb(), rb(), rb(), 1'b1, 1'b0, '0, 1'b1);
        add(1'b1, pl[i], i == len - 2, rb(), rb(), 1'b1, 1'b0, '0, 1'b1);
      end
    end
  endtask

  // Entered and left at posedge+1; outputs are compared on the falling edge.
  task automatic run_q(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) begin
      cyc_t c;
      c = q.pop_front();
      src_valid = c.v; src_flit = c.f; src_last = c.l;
      link.ack  = c.ack; link.rej = c.rej;
      @(negedge clk);
      chk("src_ready", 32'(src_ready), 32'(c.rdy));
      chk("up_enable", 32'(link.enable), 32'(c.en));
      if (c.en) chk("up_flit", link.flit, c.ef);
      chk("busy", 32'(busy), 32'(c.bsy));
      chk("err", 32'(err), 32'(c.er));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int len, nrej, srej, r;
    logic tmo;
    src_valid = 1'b0; src_flit = '0; src_last = 1'b0;
    link.ack = 1'b0; link.rej = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_enable", 32'(link.enable), 32'd0);
    chk("rst_flit", link.flit, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_first_edge", 32'(src_ready), 32'd1);

    gen_pkt(3, 0, 1'b0, -1, 2);  run_q(q.size());   // ack after 2 REQ cycles
    gen_pkt(3, 2, 1'b0, -1, 0);  run_q(q.size());   // two immediate rejects then ack
    gen_pkt(4, 5, 1'b0, -1, -1); run_q(q.size());   // retries exhausted, payload drained
    gen_pkt(2, 2, 1'b1, -1, -1); run_q(q.size());   // timeout then reject then ack
    gen_pkt(4, 0, 1'b0, 1, -1);  run_q(q.size());   // reject after one payload flit
    gen_pkt(1, 5, 1'b0, -1, -1); run_q(q.size());   // single-flit drop back to IDLE
    gen_pkt(1, 0, 1'b0, -1, -1); run_q(q.size());

    // Asynchronous reset while a packet is streaming.
    gaps_on = 1'b0;
    gen_pkt(4, 0, 1'b0, -1, 1);
    run_q(q.size() - 2);
    q.delete();
    pend_err  = 1'b0;
    src_valid = 1'b1; src_flit = $urandom; src_last = 1'b0;
    link.ack  = 1'b0; link.rej = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_src_ready", 32'(src_ready), 32'd0);
    chk("midrst_enable", 32'(link.enable), 32'd0);
    chk("midrst_flit", link.flit, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    src_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_ready", 32'(src_ready), 32'd1);
    chk("postrst_err", 32'(err), 32'd0);
    gaps_on = 1'b1;
    gen_pkt(2, 0, 1'b0, -1, -1); run_q(q.size());

    repeat (25) begin
      len = $urandom_range(1, 5);
      r = $urandom_range(0, 9);
      nrej = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 4) : 5;
      tmo = ($urandom_range(0, 7) == 0);
      srej = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 2) : -1;
      gen_pkt(len, nrej, tmo, srej, -1);
      run_q(q.size());
    end

    add(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    run_q(q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
